hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the stall and flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates the forwarding selects for the EX-stage operand muxes. It contains a small FSM that tracks multi-cycle data-memory waits and flags timeouts. Saturating counters record stall and flush events for performance monitoring.

Parameters:
TIMEOUT, 64, consecutive MEM_WAIT cycles before err_timeout sets
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
RsD, RtD  in  5  source registers of the instruction in D
RsE, RtE  in  5  source registers of the instruction in E
WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
MemtoRegE  in  1  instruction in E is a load
BranchE, ZeroE  in  1  branch instruction in E; ALU zero flag
MemAccessM  in  1  instruction in M accesses data memory
dmem_ready  in  1  data memory completes the access this cycle
clr_cnt  in  1  synchronous clear of both counters
StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register
FlushD, FlushE, FlushW  out  1  load a bubble into IF-ID / ID-EX / MEM-WB
PCSrcE  out  1  branch taken; PC loads the branch target
ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALUOutM, 01 = ResultW
err_timeout  out  1  sticky memory-timeout error
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- While rst_n is low:
  - state = RUN, wait_cnt = 0, err_timeout = 0, stall_cnt = 0, flush_cnt = 0.
  - All Stall* outputs = 0, FlushD = FlushE = FlushW = 1, PCSrcE = 0, Forward* = 00.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM and WriteRegM != 0 and WriteRegM == RsE.
  - Otherwise 01 if RegWriteW and WriteRegW != 0 and WriteRegW == RsE.
  - Otherwise 00. The M stage wins when M and W both match.
  - ForwardBE follows the same rules using RtE.
- Hazard terms:
  - PCSrcE = BranchE & ZeroE.
  - lwstall = MemtoRegE & RegWriteE & (WriteRegE != 0) & (WriteRegE == RsD | WriteRegE == RtD).
  - mem_stall = MemAccessM & ~dmem_ready.
- Priority, highest first:
  1. mem_stall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. PCSrcE is masked to 0 so a branch in E is frozen and resolves after the wait.
  2. PCSrcE: FlushD = FlushE = 1, no stalls. lwstall is ignored because the D instruction is squashed.
  3. lwstall: StallF = StallD = 1, FlushE = 1, for exactly one cycle, since the load then advances to M.
  4. Otherwise all Stall* and Flush* outputs are 0.
- FSM, states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt is set to 1.
  - MEM_WAIT stays while mem_stall; wait_cnt increments and saturates at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, err_timeout sets. It stays set until reset.
  - The stall continues after a timeout; the block does not abort the access.
  - MEM_WAIT -> RUN on the first cycle with dmem_ready = 1 (that cycle is not a stall cycle); wait_cnt is cleared.
  - A ready response in the same cycle as the request (MemAccessM & dmem_ready) causes no stall and stays in RUN.
- Counters:
  - stall_cnt increments on every cycle with StallF = 1.
  - flush_cnt increments on every cycle with PCSrcE = 1 (after masking).
  - Both saturate at 2^CNT_W - 1.
  - clr_cnt takes priority over increment in the same cycle.
- Reset asserted mid-wait returns the FSM to RUN immediately and asynchronously.

Decomposition:
- Package pipe_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - hz_state_t enum: RUN, MEM_WAIT.
  - Register-number width constant REG_W = 5.
- Sub-module fwd_unit: purely combinational forwarding for one operand. It is instantiated twice, once for A and once for B.

Test Plan:
1. RegWriteM = 1, WriteRegM = 8, RsE = 8, RegWriteW = 1, WriteRegW = 8 -> ForwardAE = 10. Then WriteRegM = 0 -> ForwardAE = 01.
2. Load in E: MemtoRegE = RegWriteE = 1, WriteRegE = 9, RtD = 9 -> StallF = StallD = FlushE = 1 for one cycle; stall_cnt = 1. With WriteRegE = 0 -> no stall.
3. BranchE = ZeroE = 1 together with a load-use condition -> FlushD = FlushE = 1, StallF = 0; flush_cnt = 1.
4. MemAccessM = 1 with dmem_ready low for 3 cycles, then high -> all Stall* and FlushW = 1 for exactly 3 cycles; state returns to RUN; stall_cnt = 3.
5. TIMEOUT = 4 and dmem_ready held low for 6 cycles -> err_timeout rises when wait_cnt reaches 4 and stays set after ready. Assert rst_n low mid-wait -> state RUN, err_timeout = 0, outputs at reset values.
6. Drive stall_cnt to saturation (CNT_W = 4, 16 stalls) -> value holds at 15. Asserting clr_cnt in a stall cycle -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller FSM states and the register-number width.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: register numbers and
// enables in, stall/flush/forward controls and monitor counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic [REG_W-1:0] RsD, RtD, RsE, RtE;
  logic [REG_W-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, BranchE, ZeroE;
  logic             MemAccessM, dmem_ready, clr_cnt;

  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             PCSrcE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchE, ZeroE,
           MemAccessM, dmem_ready, clr_cnt,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           PCSrcE, ForwardAE, ForwardBE, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchE, ZeroE,
           MemAccessM, dmem_ready, clr_cnt,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           PCSrcE, ForwardAE, ForwardBE, err_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding select for one EX-stage operand; the M-stage
// result is newer than W and therefore wins when both match.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic             reg_write_m_i,
  input  logic [REG_W-1:0] write_reg_m_i,
  input  logic             reg_write_w_i,
  input  logic [REG_W-1:0] write_reg_w_i,
  output fwd_sel_t         fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (write_reg_m_i != '0) && (write_reg_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (write_reg_w_i != '0) && (write_reg_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// priority, operand forwarding, data-memory wait tracking and event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int                WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  fwd_sel_t fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs_i          (hz.RsE),
    .reg_write_m_i (hz.RegWriteM),
    .write_reg_m_i (hz.WriteRegM),
    .reg_write_w_i (hz.RegWriteW),
    .write_reg_w_i (hz.WriteRegW),
    .fwd_o         (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_i          (hz.RtE),
    .reg_write_m_i (hz.RegWriteM),
    .write_reg_m_i (hz.WriteRegM),
    .reg_write_w_i (hz.RegWriteW),
    .write_reg_w_i (hz.WriteRegW),
    .fwd_o         (fwd_b)
  );

  logic mem_stall, lwstall, pcsrc;
  logic stall_f, stall_m, flush_d, flush_e, flush_w;

  assign mem_stall = hz.MemAccessM & ~hz.dmem_ready;
  // A branch in E is frozen during a memory wait and resolves afterwards.
  assign pcsrc     = hz.BranchE & hz.ZeroE & ~mem_stall;
  assign lwstall   = hz.MemtoRegE & hz.RegWriteE & (hz.WriteRegE != '0) &
                     ((hz.WriteRegE == hz.RsD) | (hz.WriteRegE == hz.RtD));

  always_comb begin
    stall_f = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lwstall) begin
      stall_f = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_f;
  assign hz.StallE    = stall_m;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.PCSrcE    = rst_n & pcsrc;
  assign hz.ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign hz.ForwardBE = rst_n ? fwd_b : FWD_RF;

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q != TIMEOUT_V) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    err_d = err_q | ((state_d == MEM_WAIT) && (wait_cnt_d == TIMEOUT_V));

    stall_cnt_d = stall_cnt_q;
    if (hz.clr_cnt)                         stall_cnt_d = '0;
    else if (stall_f && stall_cnt_q != '1)  stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (hz.clr_cnt)                         flush_cnt_d = '0;
    else if (pcsrc && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.err_timeout = err_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  // Model state: consecutive wait cycles (unbounded), sticky error, counters.
  int m_wait, m_stall, m_flush;
  bit m_err;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
  endtask

  task automatic idle();
    bus.RsD = '0; bus.RtD = '0; bus.RsE = '0; bus.RtE = '0;
    bus.WriteRegE = '0; bus.WriteRegM = '0; bus.WriteRegW = '0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.BranchE = 0; bus.ZeroE = 0;
    bus.MemAccessM = 0; bus.dmem_ready = 0; bus.clr_cnt = 0;
  endtask

  function automatic int fwd_for(input int src);
    if (bus.RegWriteM && bus.WriteRegM != 0 && int'(bus.WriteRegM) == src) return 2;
    if (bus.RegWriteW && bus.WriteRegW != 0 && int'(bus.WriteRegW) == src) return 1;
    return 0;
  endfunction

  // Called just after a falling edge with inputs applied; checks every output
  // against the model, advances the model across the next rising edge.
  task automatic step();
    bit ms, br, lw;
    int sF, sM, fD, fE, fW, pc, fa, fb;
    #1;
    ms = bus.MemAccessM && !bus.dmem_ready;
    br = bus.BranchE && bus.ZeroE;
    lw = bus.MemtoRegE && bus.RegWriteE && bus.WriteRegE != 0 &&
         (bus.WriteRegE == bus.RsD || bus.WriteRegE == bus.RtD);
    sF = 0; sM = 0; fD = 0; fE = 0; fW = 0; pc = 0;
    fa = fwd_for(int'(bus.RsE));
    fb = fwd_for(int'(bus.RtE));
    if (!rst_n) begin
      fD = 1; fE = 1; fW = 1; fa = 0; fb = 0;
    end else if (ms) begin
      sF = 1; sM = 1; fW = 1;
    end else if (br) begin
      pc = 1; fD = 1; fE = 1;
    end else if (lw) begin
      sF = 1; fE = 1;
    end
    check("StallF", int'(bus.StallF), sF);
    check("StallD", int'(bus.StallD), sF);
    check("StallE", int'(bus.StallE), sM);
    check("StallM", int'(bus.StallM), sM);
    check("FlushD", int'(bus.FlushD), fD);
    check("FlushE", int'(bus.FlushE), fE);
    check("FlushW", int'(bus.FlushW), fW);
    check("PCSrcE", int'(bus.PCSrcE), pc);
    check("ForwardAE", int'(bus.ForwardAE), fa);
    check("ForwardBE", int'(bus.ForwardBE), fb);
    check("err_timeout", int'(bus.err_timeout), int'(m_err));
    check("stall_cnt", int'(bus.stall_cnt), m_stall);
    check("flush_cnt", int'(bus.flush_cnt), m_flush);
    if (rst_n) begin
      if (ms) begin
        m_wait++;
        if (m_wait >= TO) m_err = 1;
      end else begin
        m_wait = 0;
      end
      if (bus.clr_cnt) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (sF != 0) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
        if (pc != 0) m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    #1;
    check("rst_FlushD", int'(bus.FlushD), 1);
    check("rst_FlushW", int'(bus.FlushW), 1);
    check("rst_StallF", int'(bus.StallF), 0);
    step();
    rst_n = 1;

    // Forwarding: M wins over W, then W alone.
    bus.RegWriteM = 1; bus.WriteRegM = 8; bus.RsE = 8;
    bus.RegWriteW = 1; bus.WriteRegW = 8;
    #1 check("fwdA_M", int'(bus.ForwardAE), 2);
    step();
    bus.WriteRegM = 0;
    #1 check("fwdA_W", int'(bus.ForwardAE), 1);
    step();
    idle();

    // Load-use stall, then the $zero destination case.
    bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.WriteRegE = 9; bus.RtD = 9;
    #1 check("lw_StallF", int'(bus.StallF), 1);
    check("lw_FlushE", int'(bus.FlushE), 1);
    step();
    bus.WriteRegE = 0;
    #1 check("lw_zero_StallF", int'(bus.StallF), 0);
    check("lw_stall_cnt", int'(bus.stall_cnt), 1);
    step();

    // Taken branch overrides a load-use condition.
    bus.WriteRegE = 9; bus.BranchE = 1; bus.ZeroE = 1;
    #1 check("br_StallF", int'(bus.StallF), 0);
    check("br_FlushD", int'(bus.FlushD), 1);
    step();
    idle();
    #1 check("br_flush_cnt", int'(bus.flush_cnt), 1);
    step();

    // Three-cycle memory wait.
    bus.clr_cnt = 1;
    step();
    bus.clr_cnt = 0;
    bus.MemAccessM = 1; bus.dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 check("mw_StallM", int'(bus.StallM), 1);
      step();
    end
    bus.dmem_ready = 1;
    #1 check("mw_ready_StallF", int'(bus.StallF), 0);
    step();
    idle();
    #1 check("mw_stall_cnt", int'(bus.stall_cnt), 3);
    step();

    // Timeout after TO wait cycles, sticky past the ready response.
    bus.MemAccessM = 1; bus.dmem_ready = 0;
    for (int k = 0; k < 6; k++) begin
      #1 check("to_err", int'(bus.err_timeout), (k >= TO) ? 1 : 0);
      step();
    end
    bus.dmem_ready = 1;
    step();
    idle();
    #1 check("to_sticky", int'(bus.err_timeout), 1);
    step();

    // Reset in the middle of a wait.
    bus.MemAccessM = 1; bus.dmem_ready = 0;
    step();
    step();
    #2 rst_n = 0;
    #1;
    check("mrst_err", int'(bus.err_timeout), 0);
    check("mrst_StallF", int'(bus.StallF), 0);
    check("mrst_FlushE", int'(bus.FlushE), 1);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1;
    bus.dmem_ready = 1;
    step();

    // Counter saturation and clear priority.
    idle();
    bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.WriteRegE = 3; bus.RsD = 3;
    for (int k = 0; k < 16; k++) step();
    #1 check("sat_stall_cnt", int'(bus.stall_cnt), CMAX);
    bus.clr_cnt = 1;
    step();
    bus.clr_cnt = 0;
    #1 check("clr_stall_cnt", int'(bus.stall_cnt), 0);
    step();

    // Random traffic.
    idle();
    for (int i = 0; i < 400; i++) begin
      bus.RsD = 5'($urandom_range(0, 3));
      bus.RtD = 5'($urandom_range(0, 3));
      bus.RsE = 5'($urandom_range(0, 3));
      bus.RtE = 5'($urandom_range(0, 3));
      bus.WriteRegE = 5'($urandom_range(0, 3));
      bus.WriteRegM = 5'($urandom_range(0, 3));
      bus.WriteRegW = 5'($urandom_range(0, 3));
      bus.RegWriteE = 1'($urandom_range(0, 1));
      bus.RegWriteM = 1'($urandom_range(0, 1));
      bus.RegWriteW = 1'($urandom_range(0, 1));
      bus.MemtoRegE = 1'($urandom_range(0, 1));
      bus.BranchE   = ($urandom_range(0, 3) == 0);
      bus.ZeroE     = 1'($urandom_range(0, 1));
      bus.MemAccessM = ($urandom_range(0, 2) == 0);
      bus.dmem_ready = ($urandom_range(0, 2) == 0);
      bus.clr_cnt    = ($urandom_range(0, 15) == 0);
      if (i == 200) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
